// File: rtl/morph_filter.sv
`default_nettype none
// ============================================================================
// Module   : morph_filter
// Brief    : 3x3 binary erosion/dilation on a thresholded video stream, 3 clk latency.
//            Define MORPH_DILATE_EN to build dilation (op_sel); otherwise erosion only.
// Revision : 1.0 - initial release
// ============================================================================
module morph_filter #(
  parameter int         IMG_WIDTH = 640,
  parameter int         OUT_WIDTH = 16,
  parameter logic [7:0] THRESH    = 8'd128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pre_frame_vsync,
  input  logic                 pre_frame_hsync,
  input  logic                 pre_frame_clken,
  input  logic [7:0]           pre_img_Y,
  input  logic                 op_sel,
  output logic                 post_frame_vsync,
  output logic                 post_frame_hsync,
  output logic                 post_frame_clken,
  output logic [OUT_WIDTH-1:0] post_img_Y
);

  localparam int              CW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0]   C_COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [10:0]     C_ROW_MAX = 11'd2047;

  logic                 r_vs_q, r_hs_q, r_seen_low, r_armed;
  logic [CW-1:0]        r_col;
  logic [10:0]          r_row;
  logic [1:0]           r_h0, r_h1, r_h2;
  logic                 r_lb0 [IMG_WIDTH];
  logic                 r_lb1 [IMG_WIDTH];
  logic [8:0]           r_win;
  logic [2:0]           r_rowred;
  logic [2:0]           r_sync1, r_sync2, r_sync3;
  logic [OUT_WIDTH-1:0] r_post_y;

  logic                 w_vs_rise, w_hs_fall, w_active, w_bin, w_up1, w_up2;
  logic                 w_mode, w_ident, w_final;
  logic [CW-1:0]        w_col;
  logic [10:0]          w_row;
  logic [2:0]           w_col_ok, w_row_ok;
  logic [8:0]           w_taps, w_win;

  // A rise only counts once vsync has been seen low, so a reset released mid-frame waits for the next frame
  assign w_vs_rise = pre_frame_vsync & ~r_vs_q & r_seen_low;
  assign w_hs_fall = ~pre_frame_hsync & r_hs_q;
  assign w_active  = r_armed | w_vs_rise;
  assign w_col     = w_vs_rise ? '0 : r_col;
  assign w_row     = w_vs_rise ? '0 : r_row;
  assign w_bin     = (pre_img_Y >= THRESH);
  assign w_up1     = r_lb0[w_col];
  assign w_up2     = r_lb1[w_col];

`ifdef MORPH_DILATE_EN
  logic r_op, r_mode1, r_mode2;
  assign w_mode = w_vs_rise ? op_sel : r_op;
`else
  logic w_unused_op_sel;
  assign w_unused_op_sel = op_sel;
  assign w_mode          = 1'b0;
`endif
  assign w_ident = ~w_mode;

  // Row groups [8:6]=r-2, [5:3]=r-1, [2:0]=r; within a group [2]=c-2, [1]=c-1, [0]=c
  assign w_taps   = {r_h2, w_up2, r_h1, w_up1, r_h0, w_bin};
  assign w_col_ok = {w_col > CW'(1), w_col != '0, 1'b1};
  assign w_row_ok = {w_row > 11'd1, w_row != '0, 1'b1};

  always_comb begin
    w_win = w_taps;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(w_row_ok[i] && w_col_ok[j])) w_win[3*i+j] = w_ident;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q     <= 1'b0;
      r_hs_q     <= 1'b0;
      r_seen_low <= 1'b0;
      r_armed    <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_h0       <= '0;
      r_h1       <= '0;
      r_h2       <= '0;
`ifdef MORPH_DILATE_EN
      r_op       <= 1'b0;
`endif
    end else begin
      r_vs_q     <= pre_frame_vsync;
      r_hs_q     <= pre_frame_hsync;
      r_seen_low <= r_seen_low | ~pre_frame_vsync;
      if (w_vs_rise) r_armed <= 1'b1;
`ifdef MORPH_DILATE_EN
      if (w_vs_rise) r_op <= op_sel;
`endif
      if (w_vs_rise) begin
        r_row <= '0;
        r_col <= pre_frame_clken ? CW'(1) : '0;
      end else if (w_hs_fall) begin
        r_col <= '0;
        if (r_row != C_ROW_MAX) r_row <= r_row + 11'd1;
      end else if (pre_frame_clken && (r_col != C_COL_MAX)) begin
        r_col <= r_col + CW'(1);
      end
      if (pre_frame_clken) begin
        r_h0 <= {r_h0[0], w_bin};
        r_h1 <= {r_h1[0], w_up1};
        r_h2 <= {r_h2[0], w_up2};
      end
    end
  end

  // Line buffers are never cleared; row/column masking hides stale contents
  always_ff @(posedge clk) begin
    if (rst_n && pre_frame_clken) begin
      r_lb1[w_col] <= w_up1;
      r_lb0[w_col] <= w_bin;
    end
  end

`ifdef MORPH_DILATE_EN
  assign w_final = r_mode2 ? |r_rowred : &r_rowred;
`else
  assign w_final = &r_rowred;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win    <= '0;
      r_rowred <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_post_y <= '0;
`ifdef MORPH_DILATE_EN
      r_mode1  <= 1'b0;
      r_mode2  <= 1'b0;
`endif
    end else begin
      r_win   <= w_win;
      r_sync1 <= {pre_frame_vsync, pre_frame_hsync, pre_frame_clken} & {3{w_active}};
      for (int i = 0; i < 3; i++) begin
`ifdef MORPH_DILATE_EN
        r_rowred[i] <= r_mode1 ? |r_win[3*i +: 3] : &r_win[3*i +: 3];
`else
        r_rowred[i] <= &r_win[3*i +: 3];
`endif
      end
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_post_y <= r_sync2[1] ? {OUT_WIDTH{w_final}} : '0;
`ifdef MORPH_DILATE_EN
      r_mode1  <= w_mode;
      r_mode2  <= r_mode1;
`endif
    end
  end

  assign post_frame_vsync = r_sync3[2];
  assign post_frame_hsync = r_sync3[1];
  assign post_frame_clken = r_sync3[0];
  assign post_img_Y       = r_post_y;

endmodule
`default_nettype wire

// File: tb/tb_morph_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_morph_filter
// Brief    : Scoreboard bench for morph_filter (8x8 frames, golden 3x3 model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_morph_filter;
  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        vs = 1'b0, hs = 1'b0, ck = 1'b0, op = 1'b0;
  logic [7:0]  y = 8'd0;
  logic        post_vs, post_hs, post_ck;
  logic [15:0] post_y;

  morph_filter #(.IMG_WIDTH(W), .OUT_WIDTH(16), .THRESH(8'd128)) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_clken(ck),
    .pre_img_Y(y), .op_sel(op),
    .post_frame_vsync(post_vs), .post_frame_hsync(post_hs),
    .post_frame_clken(post_ck), .post_img_Y(post_y)
  );

  always #5 clk = ~clk;

  typedef struct {bit vs; bit hs; bit ck; logic [7:0] y; int r; int c;} stim_t;
  typedef struct {logic [15:0] v; int due;} exp_t;

  stim_t       stim[$];
  exp_t        sb[$];
  logic [2:0]  hist[$];
  logic [7:0]  pix [H][W];
  logic [15:0] exp_frame [H][W];
  int          errors = 0, checks = 0, cyc = 0, rst_hold = 0;
  bit          gate = 1'b0;

  function automatic logic [15:0] model(input int r, input int c, input bit dil);
    bit acc = ~dil;
    for (int dr = -2; dr <= 0; dr++) begin
      for (int dc = -2; dc <= 0; dc++) begin
        bit t;
        if (r + dr < 0 || c + dc < 0) t = ~dil;
        else t = (pix[r+dr][c+dc] >= 8'd128);
        acc = dil ? (acc | t) : (acc & t);
      end
    end
    return {16{acc}};
  endfunction

  task automatic build(input bit gaps);
    stim.delete();
    repeat (3) stim.push_back('{1'b0, 1'b0, 1'b0, 8'd0, -1, -1});
    repeat (2) stim.push_back('{1'b1, 1'b0, 1'b0, 8'd0, -1, -1});
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        stim.push_back('{1'b1, 1'b1, 1'b1, pix[r][c], r, c});
        if (gaps && (c % 3 == 1)) stim.push_back('{1'b1, 1'b1, 1'b0, 8'd0, -1, -1});
      end
      repeat (3) stim.push_back('{1'b1, 1'b0, 1'b0, 8'd0, -1, -1});
    end
    repeat (6) stim.push_back('{1'b0, 1'b0, 1'b0, 8'd0, -1, -1});
  endtask

  // Drives one frame; scoreboard and sync-history comparisons happen as outputs emerge
  task automatic run_frame(input string name, input bit op_start, input bit gaps,
                           input int tog_row, input int rst_row);
    bit dil;
`ifdef MORPH_DILATE_EN
    dil = op_start;
`else
    dil = 1'b0;
`endif
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_frame[r][c] = model(r, c, dil);
    build(gaps);
    op   = op_start;
    gate = 1'b1;
    foreach (stim[k]) begin
      stim_t s = stim[k];
      logic [2:0] eh;
      @(posedge clk); #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end
      if (s.ck && s.c == 3 && s.r == tog_row) op = ~op;
      if (s.ck && s.c == 3 && s.r == rst_row) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({post_vs, post_hs, post_ck, post_y} !== 19'd0) begin
          errors++;
          $display("FAIL %s reset_outputs got %b/%b/%b/%h required 0", name, post_vs, post_hs, post_ck, post_y);
        end
        sb.delete();
        hist.delete();
        repeat (3) hist.push_back(3'b0);
        gate     = 1'b0;
        rst_hold = 3;
      end
      vs = s.vs; hs = s.hs; ck = s.ck; y = s.y;
      if (s.ck && gate) sb.push_back('{exp_frame[s.r][s.c], cyc + 3});
      hist.push_back({s.vs, s.hs, s.ck} & {3{gate}});
      @(negedge clk);
      eh = hist.pop_front();
      checks++;
      if ({post_vs, post_hs, post_ck} !== eh) begin
        errors++;
        $display("FAIL %s sync cyc=%0d got %b required %b", name, cyc, {post_vs, post_hs, post_ck}, eh);
      end
      if (post_ck) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_pixel cyc=%0d got %h required none", name, cyc, post_y);
        end else begin
          exp_t e = sb.pop_front();
          if (post_y !== e.v || cyc != e.due) begin
            errors++;
            $display("FAIL %s pixel cyc=%0d got %h required %h at cyc %0d", name, cyc, post_y, e.v, e.due);
          end
        end
      end
      if (!post_hs) begin
        checks++;
        if (post_y !== 16'h0) begin
          errors++;
          $display("FAIL %s blank_zero cyc=%0d got %h required 0000", name, cyc, post_y);
        end
      end
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pixels got %0d outstanding required 0", name, sb.size());
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r][c] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({post_vs, post_hs, post_ck, post_y} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got %b/%b/%b/%h required 0", post_vs, post_hs, post_ck, post_y);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({post_vs, post_hs, post_ck, post_y} !== 19'd0) begin
      errors++;
      $display("FAIL idle_after_reset got %b/%b/%b/%h required 0", post_vs, post_hs, post_ck, post_y);
    end
    hist.delete();
    repeat (3) hist.push_back(3'b0);
  endtask

  task automatic test_erode_all_ones();
    fill(8'd255);
    run_frame("erode_all255", 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_erode_hole();
    fill(8'd255);
    pix[3][4] = 8'd0;
    run_frame("erode_hole", 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_dilate_point();
    fill(8'd0);
    pix[3][4] = 8'd255;
    run_frame("dilate_point", 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_threshold();
    fill(8'd255);
    pix[2][2] = 8'd127;
    pix[5][5] = 8'd128;
    run_frame("thresh_dilate", 1'b1, 1'b0, -1, -1);
    run_frame("thresh_erode", 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_op_toggle();
    fill_random();
    run_frame("toggle_cur", 1'b0, 1'b1, 3, -1);
    fill_random();
    run_frame("toggle_next", 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_reset_midframe();
    fill_random();
    run_frame("reset_abort", 1'b0, 1'b0, -1, 4);
    fill_random();
    run_frame("reset_next", 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_frame("b2b_a", 1'b1, 1'b1, -1, -1);
    fill_random();
    run_frame("b2b_b", 1'b0, 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_erode_all_ones();
    test_erode_hole();
    test_dilate_point();
    test_threshold();
    test_op_toggle();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
